// File: rtl/fu_div_sched.sv
// rtl/fu_div_sched.sv - round-robin scheduler sharing one fixed-latency divider among divide stations
module fu_div_sched #(
  parameter int NUM_RS = 3,
  parameter int TAG_W  = 6,
  parameter int LAT    = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RS-1:0]       rs_req,
  input  logic [NUM_RS*32-1:0]    rs_a,
  input  logic [NUM_RS*32-1:0]    rs_b,
  input  logic [NUM_RS*TAG_W-1:0] rs_tag,
  output logic [NUM_RS-1:0]       rs_ack,
  input  logic                    flush,
  output logic                    div_start,
  output logic [31:0]             div_a,
  output logic [31:0]             div_b,
  input  logic [31:0]             div_res,
  output logic                    cdb_req,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [31:0]             cdb_data,
  input  logic                    cdb_grant,
  output logic                    busy
);
  localparam int PW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int CW = $clog2(LAT) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [CW-1:0]     counter;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     cand;
  logic [PW-1:0]     next_ptr;
  logic              grant_vld;
  logic [NUM_RS-1:0] ack_vec;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic [TAG_W-1:0]  sel_tag;

  // Scan downward so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = NUM_RS - 1; k >= 0; k--) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_RS);
      if (rs_req[cand]) begin
        grant_idx = cand;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ack_vec = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (PW'(k) == grant_idx) begin
        ack_vec[k] = 1'b1;
        sel_a      = rs_a[32*k +: 32];
        sel_b      = rs_b[32*k +: 32];
        sel_tag    = rs_tag[TAG_W*k +: TAG_W];
      end
    end
  end

  assign next_ptr = (grant_idx == PW'(NUM_RS - 1)) ? '0 : grant_idx + PW'(1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      counter   <= '0;
      rs_ack    <= '0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      cdb_req   <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      rs_ack    <= '0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && grant_vld) begin
            rs_ack    <= ack_vec;
            div_a     <= sel_a;
            div_b     <= sel_b;
            cdb_tag   <= sel_tag;
            div_start <= 1'b1;
            counter   <= '0;
            rr_ptr    <= next_ptr;
            state     <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            counter <= '0;
            state   <= IDLE;
          end else if (counter == CW'(LAT - 1)) begin
            cdb_data <= div_res;
            cdb_req  <= 1'b1;
            state    <= DONE;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        DONE: begin
          // A flush drops the result even if the CDB grants it in the same cycle.
          if (flush) begin
            cdb_req <= 1'b0;
            counter <= '0;
            state   <= IDLE;
          end else if (cdb_grant) begin
            cdb_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          cdb_req <= 1'b0;
          counter <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fu_div_sched.sv
// tb/tb_fu_div_sched.sv - self-checking bench for fu_div_sched
module tb_fu_div_sched;
  localparam int NUM_RS = 3;
  localparam int TAG_W  = 6;
  localparam int LAT    = 23;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_RS-1:0]       rs_req;
  logic [NUM_RS*32-1:0]    rs_a;
  logic [NUM_RS*32-1:0]    rs_b;
  logic [NUM_RS*TAG_W-1:0] rs_tag;
  logic [NUM_RS-1:0]       rs_ack;
  logic                    flush;
  logic                    div_start;
  logic [31:0]             div_a;
  logic [31:0]             div_b;
  logic [31:0]             div_res;
  logic                    cdb_req;
  logic [TAG_W-1:0]        cdb_tag;
  logic [31:0]             cdb_data;
  logic                    cdb_grant;
  logic                    busy;

  fu_div_sched #(.NUM_RS(NUM_RS), .TAG_W(TAG_W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .rs_req(rs_req), .rs_a(rs_a), .rs_b(rs_b),
    .rs_tag(rs_tag), .rs_ack(rs_ack), .flush(flush), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .div_res(div_res), .cdb_req(cdb_req),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_grant(cdb_grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               st;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    int               gdly;
    logic [NUM_RS-1:0] exp_ack;
    logic [31:0]      exp_q;
  } vec_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      q;
  } exp_t;

  vec_t              vt [5];
  exp_t              sbq [$];
  exp_t              sb_e;
  logic [NUM_RS-1:0] exp_rr [4];
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] qmodel(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  // Divider model: garbage until LAT-1 cycles after the start strobe, then the quotient.
  int          dcnt = 0;
  logic [31:0] dq   = '0;
  always @(posedge clk) begin
    if (div_start) begin
      dq   <= qmodel(div_a, div_b);
      dcnt <= 1;
    end else if (dcnt != 0 && dcnt < 1000) begin
      dcnt <= dcnt + 1;
    end
  end
  assign div_res = (dcnt >= LAT - 1) ? dq : 32'hDEAD_BEEF;

  // Scoreboard: push on each accepted request, pop on each CDB handshake.
  always @(posedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (rs_ack != '0) begin
        chk("ack_onehot", $countones(rs_ack), 1);
        for (int i = 0; i < NUM_RS; i++) begin
          if (rs_ack[i]) begin
            sb_e.tag = rs_tag[TAG_W*i +: TAG_W];
            sb_e.q   = qmodel(rs_a[32*i +: 32], rs_b[32*i +: 32]);
            sbq.push_back(sb_e);
          end
        end
      end
      if (flush && busy) begin
        if (sbq.size() != 0) void'(sbq.pop_front());
      end else if (cdb_req && cdb_grant) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_result", 1, 0);
        end else begin
          sb_e = sbq.pop_front();
          chk("sb_tag", cdb_tag, sb_e.tag);
          chk("sb_data", cdb_data, sb_e.q);
        end
      end
    end
  end

  task automatic set_st(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
    rs_a[32*i +: 32]       = a;
    rs_b[32*i +: 32]       = b;
    rs_tag[TAG_W*i +: TAG_W] = tag;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (rs_ack == '0 && n < 100);
    chk("ack_seen", rs_ack != '0, 1);
  endtask

  task automatic wait_cdb(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!cdb_req && n < 200);
    chk("cdb_req_seen", cdb_req, 1);
  endtask

  task automatic grant_once();
    cdb_grant = 1'b1;
    @(negedge clk);
    cdb_grant = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int last;
    int acks_seen;

    vt[0] = '{0, 32'd100,        32'd7,    6'd5,  0, 3'b001, 32'd14};
    vt[1] = '{1, 32'hFFFF_FFFF,  32'd1,    6'd63, 3, 3'b010, 32'hFFFF_FFFF};
    vt[2] = '{2, 32'd5,          32'd0,    6'h2A, 1, 3'b100, 32'hFFFF_FFFF};
    vt[3] = '{0, 32'd1000000,    32'd1000, 6'd9,  0, 3'b001, 32'd1000};
    vt[4] = '{1, 32'h8000_0000,  32'h10,   6'h11, 2, 3'b010, 32'h0800_0000};
    exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100; exp_rr[3] = 3'b001;

    rst_n = 1'b0; rs_req = '0; rs_a = '0; rs_b = '0; rs_tag = '0;
    flush = 1'b0; cdb_grant = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {rs_ack, div_start, cdb_req, busy, cdb_tag}, 0);
    chk("reset_div", {div_a, div_b}, 0);
    chk("reset_cdb", cdb_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requests, varied operands and CDB grant delays.
    for (int v = 0; v < 5; v++) begin
      set_st(vt[v].st, vt[v].a, vt[v].b, vt[v].tag);
      rs_req = 3'(1 << vt[v].st);
      wait_ack(n);
      rs_req = '0;
      chk("v_ack", rs_ack, vt[v].exp_ack);
      chk("v_start", div_start, 1);
      chk("v_div_ops", {div_a, div_b}, {vt[v].a, vt[v].b});
      @(negedge clk);
      chk("v_ack_pulse", {rs_ack, div_start}, 0);
      wait_cdb(n);
      chk("v_latency", n + 1, LAT);
      chk("v_div_hold", {div_a, div_b}, {vt[v].a, vt[v].b});
      chk("v_cdb", {cdb_req, cdb_tag, cdb_data}, {1'b1, vt[v].tag, vt[v].exp_q});
      for (int d = 0; d < vt[v].gdly; d++) begin
        @(negedge clk);
        chk("v_cdb_hold", {cdb_req, cdb_tag, cdb_data}, {1'b1, vt[v].tag, vt[v].exp_q});
      end
      grant_once();
      chk("v_release", {cdb_req, busy}, 0);
    end

    // Round-robin with all stations requesting and the CDB always granting.
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    set_st(0, 32'd90, 32'd9, 6'd10);
    set_st(1, 32'd91, 32'd7, 6'd11);
    set_st(2, 32'd92, 32'd4, 6'd12);
    rs_req = 3'b111; cdb_grant = 1'b1;
    acks_seen = 0; last = 0;
    for (int c = 1; c <= 300 && acks_seen < 4; c++) begin
      @(negedge clk);
      if (rs_ack != '0) begin
        chk("rr_order", rs_ack, exp_rr[acks_seen]);
        if (acks_seen > 0) chk("rr_spacing", c - last, LAT + 2);
        last = c;
        acks_seen++;
      end
    end
    rs_req = '0;
    chk("rr_count", acks_seen, 4);
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 100);
    chk("rr_drain", busy, 0);
    cdb_grant = 1'b0;

    // CDB backpressure with a second request pending.
    set_st(0, 32'd81, 32'd9, 6'd20);
    set_st(1, 32'd50, 32'd5, 6'd21);
    rs_req = 3'b001;
    wait_ack(n);
    rs_req = 3'b010;
    wait_cdb(n);
    chk("bp_latency", n, LAT);
    for (int d = 0; d < 10; d++) begin
      @(negedge clk);
      chk("bp_hold", {cdb_req, cdb_tag, cdb_data, rs_ack}, {1'b1, 6'd20, 32'd9, 3'b000});
    end
    grant_once();
    chk("bp_release", {cdb_req, rs_ack}, 0);
    @(negedge clk);
    chk("bp_next_ack", rs_ack, 3'b010);
    rs_req = '0;
    wait_cdb(n);
    chk("bp2_latency", n, LAT);
    grant_once();

    // Flush in the middle of RUN, then a fresh request.
    set_st(2, 32'd77, 32'd7, 6'd30);
    set_st(0, 32'd64, 32'd8, 6'd31);
    rs_req = 3'b100;
    wait_ack(n);
    rs_req = '0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_run_idle", {busy, cdb_req}, 0);
    rs_req = 3'b001;
    wait_ack(n);
    rs_req = '0;
    chk("flush_new_ack", {n, rs_ack}, {32'd1, 3'b001});
    wait_cdb(n);
    chk("flush_new_latency", n, LAT);
    chk("flush_new_tag", {cdb_tag, cdb_data}, {6'd31, 32'd8});
    grant_once();

    // Flush and grant collide in DONE with another request waiting.
    set_st(0, 32'd9, 32'd3, 6'd40);
    set_st(1, 32'd8, 32'd2, 6'd41);
    rs_req = 3'b001;
    wait_ack(n);
    rs_req = '0;
    wait_cdb(n);
    flush = 1'b1; cdb_grant = 1'b1; rs_req = 3'b010;
    @(negedge clk);
    flush = 1'b0; cdb_grant = 1'b0;
    chk("collide_drop", {cdb_req, busy, rs_ack}, 0);
    @(negedge clk);
    chk("collide_next_ack", rs_ack, 3'b010);
    rs_req = '0;

    // Synchronous reset while DONE, then flush blocking acceptance in IDLE.
    wait_cdb(n);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_done_ctl", {rs_ack, div_start, cdb_req, busy, cdb_tag}, 0);
    chk("rst_done_data", {div_a, div_b, cdb_data}, 0);
    set_st(2, 32'd33, 32'd11, 6'd42);
    rs_req = 3'b110; flush = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    chk("flush_idle_block", {rs_ack, busy}, 0);
    flush = 1'b0;
    @(negedge clk);
    chk("rst_rr_ptr", rs_ack, 3'b010);
    rs_req = '0;
    wait_cdb(n);
    chk("rst_rr_result", {cdb_tag, cdb_data}, {6'd41, 32'd4});
    grant_once();

    @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fu_div_sched.md
Name: fu_div_sched

Overview:
- Scheduler that shares the single fixed-latency divider functional unit among NUM_RS divide reservation stations in the Tomasulo core.
- Picks one ready station round-robin and latches its operands and tag.
- Pulses a start strobe to the divider and counts the divider latency.
- Presents the result and tag to the CDB arbiter, holding it until granted; a flush aborts any in-flight operation.

Parameters:
NUM_RS, 3, number of divide reservation stations sharing the divider (2..8)
TAG_W, 6, width of the reservation-station tag carried to the CDB
LAT, 23, divider latency in cycles from div_start high to result valid on div_res (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
rs_req  input  NUM_RS  station i has both operands ready and requests the divider
rs_a  input  NUM_RS*32  dividends, station i at bits [32i+31:32i]
rs_b  input  NUM_RS*32  divisors, same packing
rs_tag  input  NUM_RS*TAG_W  tags, station i at [TAG_W*i+TAG_W-1:TAG_W*i]
rs_ack  output  NUM_RS  one-hot, one-cycle pulse: station i's request accepted
flush  input  1  abort in-flight operation (branch mispredict)
div_start  output  1  one-cycle start strobe to divider
div_a  output  32  registered dividend to divider
div_b  output  32  registered divisor to divider
div_res  input  32  divider quotient, valid LAT cycles after div_start
cdb_req  output  1  result ready, request CDB
cdb_tag  output  TAG_W  tag of the result on CDB
cdb_data  output  32  quotient on CDB
cdb_grant  input  1  CDB arbiter accepts the result this cycle
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst_n low at edge):
  - state=IDLE, rr_ptr=0, counter=0.
  - rs_ack=0, div_start=0, div_a=div_b=0, cdb_req=0, cdb_tag=0, cdb_data=0, busy=0.
  - Reset mid-operation discards the operation; no ack or cdb_req follows.
- States: IDLE, RUN, DONE. Encoding is free; unused encodings return to IDLE.
- IDLE:
  - If flush=0 and rs_req!=0, grant the first set bit scanning from rr_ptr upward with wrap.
  - Registered outputs at the edge:
    - rs_ack[g]=1 for one cycle.
    - div_a/div_b/cdb_tag latched from station g; div_start=1.
    - counter=0, rr_ptr=(g+1) mod NUM_RS, state->RUN.
  - If rs_req=0 or flush=1: no grant; rr_ptr unchanged.
- RUN:
  - div_start returns to 0 after exactly one cycle.
  - div_a/div_b are held stable for the whole operation.
  - counter increments each cycle. When counter==LAT-1: cdb_data<=div_res, cdb_req<=1, state->DONE.
  - Net effect: cdb_req rises exactly LAT cycles after the cycle div_start was high.
- DONE:
  - cdb_req, cdb_tag and cdb_data are held stable until a cycle with cdb_grant=1.
  - At that edge: cdb_req<=0, state->IDLE.
  - A new grant is possible on the following cycle, so the minimum issue interval is LAT+2 cycles.
  - cdb_grant while cdb_req=0 is ignored.
- flush:
  - In RUN or DONE: next edge state->IDLE, cdb_req=0, div_start=0, counter=0.
  - The divider's late output is ignored.
  - flush and cdb_grant in the same DONE cycle: flush wins (result dropped).
  - flush in IDLE blocks acceptance that cycle.
- Arithmetic:
  - No division is done here. div_res is passed through unchanged, including the divide-by-zero value the divider produces.
  - Counter width is clog2(LAT)+1. The counter never wraps because it exits at LAT-1.
- rs_req is ignored outside IDLE; rs_ack never pulses outside an IDLE->RUN transition.
- At most one bit of rs_ack is high in any cycle.

Test Plan:
- Reset then single request: rs_req=001, A=100, B=7, tag=5, divider model returns 14 after LAT=23 -> rs_ack=001 one cycle; div_start one cycle; cdb_req rises 23 cycles after div_start with tag=5, data=14.
- Round-robin fairness: rs_req=111 held, cdb_grant tied 1 -> acks in order 001,010,100,001; each ack exactly LAT+2 cycles apart.
- CDB backpressure: cdb_grant held 0 for 10 cycles after cdb_req -> cdb_req/tag/data stable all 10 cycles, no new rs_ack; grant once -> cdb_req falls next edge and the next request is acked the edge after.
- Flush mid-RUN: flush at counter=10 -> state IDLE next cycle, cdb_req never asserts for that tag; a new request one cycle later completes normally with its own tag.
- Flush and grant collide in DONE: flush=1, cdb_grant=1 same cycle -> cdb_req=0 next edge, busy=0; pending rs_req=010 blocked during the flush cycle and acked on the cycle after.
- Synchronous reset mid-DONE: rst_n=0 for one edge while cdb_req=1 -> all outputs 0; rr_ptr=0, so rs_req=110 next grants station 1 (010).
